// File: rtl/bcd_counter_ndigit_if.sv
// Control and data bundle of the multi-digit BCD counter.
// Ports: enable/mode/load/load_value in, count/flags out.
interface bcd_counter_ndigit_if #(
    parameter int NUM_DIGITS = 4
);
    localparam int W = 4 * NUM_DIGITS;

    logic         enable;
    logic         mode;
    logic         load;
    logic [W-1:0] load_value;
    logic [W-1:0] count;
    logic         terminal_count;
    logic         load_error;
    logic         is_zero;

    modport master (
        output enable,
        output mode,
        output load,
        output load_value,
        input  count,
        input  terminal_count,
        input  load_error,
        input  is_zero
    );

    modport slave (
        input  enable,
        input  mode,
        input  load,
        input  load_value,
        output count,
        output terminal_count,
        output load_error,
        output is_zero
    );
endinterface

// File: rtl/bcd_counter_ndigit.sv
// NUM_DIGITS-decade BCD up/down counter, BCD-checked load, wrap/saturate.
// Ports: clk, rst_n (async, active low), bus (slave side of the bundle).
module bcd_counter_ndigit #(
    parameter int NUM_DIGITS = 4,
    parameter bit WRAP       = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    bcd_counter_ndigit_if.slave  bus
);
    localparam int W = 4 * NUM_DIGITS;

    logic [W-1:0] cnt_q;
    logic         tc_q;
    logic         lerr_q;

    logic [W-1:0] up_next;
    logic [W-1:0] dn_next;
    logic         at_max;
    logic         at_min;
    logic         carry;
    logic         borrow;
    logic [3:0]   dig;
    logic         load_ok;
    logic         at_limit;
    logic [W-1:0] step_next;

    // Ripple carry/borrow across decades. After the loop the running
    // carry/borrow flags equal "all nines" / "all zeros", which is
    // exactly the limit detection, and the chain wraps naturally.
    always_comb begin
        up_next = cnt_q;
        dn_next = cnt_q;
        carry   = 1'b1;
        borrow  = 1'b1;
        dig     = 4'd0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            dig = cnt_q[4*i +: 4];
            if (carry)
                up_next[4*i +: 4] = (dig == 4'd9) ? 4'd0 : 4'(dig + 4'd1);
            if (borrow)
                dn_next[4*i +: 4] = (dig == 4'd0) ? 4'd9 : 4'(dig - 4'd1);
            carry  = carry  & (dig == 4'd9);
            borrow = borrow & (dig == 4'd0);
        end
        at_max = carry;
        at_min = borrow;
    end

    always_comb begin
        load_ok = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (bus.load_value[4*i +: 4] > 4'd9)
                load_ok = 1'b0;
        end
    end

    assign at_limit  = bus.mode ? at_min : at_max;
    assign step_next = bus.mode ? dn_next : up_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            tc_q   <= 1'b0;
            lerr_q <= 1'b0;
        end else begin
            unique case (1'b1)
                bus.load: begin
                    tc_q   <= 1'b0;
                    lerr_q <= !load_ok;
                    if (load_ok)
                        cnt_q <= bus.load_value;
                end
                (!bus.load && bus.enable): begin
                    lerr_q <= 1'b0;
                    tc_q   <= at_limit;
                    // Saturating mode freezes at the limit.
                    if (WRAP || !at_limit)
                        cnt_q <= step_next;
                end
                default: begin
                    tc_q   <= 1'b0;
                    lerr_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.count          = cnt_q;
    assign bus.terminal_count = tc_q;
    assign bus.load_error     = lerr_q;
    assign bus.is_zero        = (cnt_q == '0);
endmodule

// File: tb/tb_bcd_counter_ndigit.sv
// Directed bench: 2-digit counter, one wrapping and one saturating instance.
// Ports: none (top-level bench).
module tb_bcd_counter_ndigit;
    logic clk = 1'b0;
    logic rst_n;
    int   n_pass = 0;
    int   n_tot  = 0;

    always #5 clk = ~clk;

    bcd_counter_ndigit_if #(.NUM_DIGITS(2)) bw ();
    bcd_counter_ndigit_if #(.NUM_DIGITS(2)) bs ();

    bcd_counter_ndigit #(.NUM_DIGITS(2), .WRAP(1'b1)) u_wrap (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bw.slave)
    );

    bcd_counter_ndigit #(.NUM_DIGITS(2), .WRAP(1'b0)) u_sat (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bs.slave)
    );

    task automatic chk(input string tag, input logic [15:0] got,
                       input logic [15:0] exp);
        n_tot++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drv_w(input logic ld, input logic [7:0] lv,
                         input logic en, input logic md);
        bw.load       = ld;
        bw.load_value = lv;
        bw.enable     = en;
        bw.mode       = md;
    endtask

    task automatic drv_s(input logic ld, input logic [7:0] lv,
                         input logic en, input logic md);
        bs.load       = ld;
        bs.load_value = lv;
        bs.enable     = en;
        bs.mode       = md;
    endtask

    function automatic logic [7:0] bcd(input int n);
        return {4'(n / 10), 4'(n % 10)};
    endfunction

    initial begin
        rst_n = 1'b0;
        drv_w(1'b0, 8'h00, 1'b0, 1'b0);
        drv_s(1'b0, 8'h00, 1'b0, 1'b0);
        #1;
        chk("rst_count", 16'(bw.count), 16'h00);
        chk("rst_tc", 16'(bw.terminal_count), 16'h0);
        chk("rst_lerr", 16'(bw.load_error), 16'h0);
        chk("rst_zero", 16'(bw.is_zero), 16'h1);
        #11;
        rst_n = 1'b1;
        #2;

        // 1: up through a full wrap
        drv_w(1'b0, 8'h00, 1'b1, 1'b0);
        for (int k = 0; k < 100; k++) begin
            cyc();
            chk("up_count", 16'(bw.count), 16'(bcd((k + 1) % 100)));
            chk("up_tc", 16'(bw.terminal_count), 16'(k == 99));
        end
        chk("up_zero", 16'(bw.is_zero), 16'h1);

        // 2: load then borrow across decades, then wrap down
        drv_w(1'b1, 8'h10, 1'b0, 1'b0);
        cyc();
        chk("ld10", 16'(bw.count), 16'h10);
        chk("ld10_lerr", 16'(bw.load_error), 16'h0);
        drv_w(1'b0, 8'h00, 1'b1, 1'b1);
        cyc();
        chk("dn09", 16'(bw.count), 16'h09);
        chk("dn09_tc", 16'(bw.terminal_count), 16'h0);
        cyc();
        chk("dn08", 16'(bw.count), 16'h08);
        chk("dn08_tc", 16'(bw.terminal_count), 16'h0);
        drv_w(1'b1, 8'h00, 1'b0, 1'b1);
        cyc();
        chk("ld00_zero", 16'(bw.is_zero), 16'h1);
        drv_w(1'b0, 8'h00, 1'b1, 1'b1);
        cyc();
        chk("dnwrap", 16'(bw.count), 16'h99);
        chk("dnwrap_tc", 16'(bw.terminal_count), 16'h1);
        chk("dnwrap_zero", 16'(bw.is_zero), 16'h0);

        // 3: rejected and accepted loads
        drv_w(1'b1, 8'h3A, 1'b0, 1'b0);
        cyc();
        chk("bad_hold", 16'(bw.count), 16'h99);
        chk("bad_lerr", 16'(bw.load_error), 16'h1);
        chk("bad_tc", 16'(bw.terminal_count), 16'h0);
        drv_w(1'b0, 8'h00, 1'b0, 1'b0);
        cyc();
        chk("lerr_clr", 16'(bw.load_error), 16'h0);
        chk("idle_hold", 16'(bw.count), 16'h99);
        drv_w(1'b1, 8'hA2, 1'b0, 1'b0);
        cyc();
        chk("bad_hi", 16'(bw.load_error), 16'h1);
        drv_w(1'b1, 8'h42, 1'b0, 1'b0);
        cyc();
        chk("ld42", 16'(bw.count), 16'h42);
        chk("ld42_lerr", 16'(bw.load_error), 16'h0);

        // 4: saturating instance
        drv_w(1'b0, 8'h00, 1'b0, 1'b0);
        drv_s(1'b1, 8'h99, 1'b0, 1'b0);
        cyc();
        chk("s_ld99", 16'(bs.count), 16'h99);
        drv_s(1'b0, 8'h00, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk("s_sat", 16'(bs.count), 16'h99);
            chk("s_sat_tc", 16'(bs.terminal_count), 16'h1);
        end
        drv_s(1'b0, 8'h00, 1'b1, 1'b1);
        cyc();
        chk("s_dn98", 16'(bs.count), 16'h98);
        chk("s_dn98_tc", 16'(bs.terminal_count), 16'h0);
        drv_s(1'b1, 8'h00, 1'b0, 1'b1);
        cyc();
        drv_s(1'b0, 8'h00, 1'b1, 1'b1);
        cyc();
        chk("s_sat0", 16'(bs.count), 16'h00);
        chk("s_sat0_tc", 16'(bs.terminal_count), 16'h1);

        // 5: load beats enable
        drv_w(1'b1, 8'h05, 1'b0, 1'b0);
        cyc();
        drv_w(1'b1, 8'h23, 1'b1, 1'b0);
        cyc();
        chk("ld_prio", 16'(bw.count), 16'h23);
        chk("ld_prio_tc", 16'(bw.terminal_count), 16'h0);
        drv_w(1'b1, 8'h56, 1'b0, 1'b0);
        cyc();
        drv_w(1'b0, 8'h00, 1'b1, 1'b0);
        cyc();
        chk("c57", 16'(bw.count), 16'h57);

        // 6: async reset mid-operation
        drv_w(1'b1, 8'hFF, 1'b1, 1'b0);
        cyc();
        chk("pre_lerr", 16'(bw.load_error), 16'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_count", 16'(bw.count), 16'h00);
        chk("ar_tc", 16'(bw.terminal_count), 16'h0);
        chk("ar_lerr", 16'(bw.load_error), 16'h0);
        chk("ar_zero", 16'(bw.is_zero), 16'h1);
        chk("ar_s_tc", 16'(bs.terminal_count), 16'h0);
        cyc();
        chk("ar_held", 16'(bw.count), 16'h00);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
